// File: rtl/can_xcvr_ctrl.sv
// Sequencing controller between the CAN protocol engine and the transceiver:
// standby pin sequencing, TXD dominant timeout and remote wake-up detection.
module can_xcvr_ctrl #(
    parameter int unsigned WAKE_CYCLES = 64,
    parameter int unsigned DOM_TIMEOUT = 4096,
    parameter int unsigned IDLE_CYCLES = 1024,
    parameter int unsigned WUP_FILT    = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic auto_sleep_i,
    input  logic fault_clr_i,
    input  logic ctrl_tx_i,
    input  logic xcvr_rx_i,
    output logic xcvr_tx_o,
    output logic xcvr_rs_o,
    output logic ctrl_rx_o,
    output logic ready_o,
    output logic dom_fault_o,
    output logic wake_o
);

    localparam logic [1:0] ST_STANDBY = 2'd0;
    localparam logic [1:0] ST_WAKE    = 2'd1;
    localparam logic [1:0] ST_NORMAL  = 2'd2;
    localparam logic [1:0] ST_FAULT   = 2'd3;

    localparam logic [15:0] WAKE_LAST  = 16'(WAKE_CYCLES - 1);
    localparam logic [15:0] DOM_LAST   = 16'(DOM_TIMEOUT - 1);
    localparam logic [15:0] IDLE_LIMIT = 16'(IDLE_CYCLES);
    localparam logic [15:0] WUP_LIMIT  = 16'(WUP_FILT);

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    logic [15:0] wup_cnt_q, wup_cnt_d;
    logic        wup_armed_q, wup_armed_d;
    logic        sleep_hold_q, sleep_hold_d;
    logic        dom_fault_q, dom_fault_d;
    logic        wake_q, wake_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idle_cnt_d   = idle_cnt_q;
        wup_cnt_d    = wup_cnt_q;
        wup_armed_d  = wup_armed_q;
        sleep_hold_d = sleep_hold_q;
        dom_fault_d  = dom_fault_q;
        wake_d       = 1'b0;

        // Wake-up filter fires once per dominant run; re-arms on a recessive sample
        if (state_q == ST_STANDBY && !xcvr_rx_i) begin
            wup_cnt_d = sat_inc(wup_cnt_q);
            if (wup_armed_q && wup_cnt_d >= WUP_LIMIT) begin
                wake_d       = 1'b1;
                wup_armed_d  = 1'b0;
                sleep_hold_d = 1'b0;
            end
        end else begin
            wup_cnt_d   = 16'd0;
            wup_armed_d = 1'b1;
        end

        if (fault_clr_i && (state_q != ST_FAULT || ctrl_tx_i)) begin
            dom_fault_d = 1'b0;
        end

        case (state_q)
            ST_STANDBY: begin
                if (en_i && !sleep_hold_q) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (!en_i) begin
                    state_d = ST_STANDBY;
                end else if (cnt_q == WAKE_LAST) begin
                    state_d = ST_NORMAL;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_NORMAL: begin
                cnt_d      = ctrl_tx_i ? 16'd0 : sat_inc(cnt_q);
                idle_cnt_d = (ctrl_tx_i && xcvr_rx_i) ? sat_inc(idle_cnt_q) : 16'd0;
                // Disable beats the dominant timeout, which beats idle sleep
                if (!en_i) begin
                    state_d = ST_STANDBY;
                end else if (!ctrl_tx_i && cnt_q == DOM_LAST) begin
                    state_d     = ST_FAULT;
                    dom_fault_d = 1'b1;
                end else if (auto_sleep_i && ctrl_tx_i && xcvr_rx_i && idle_cnt_d >= IDLE_LIMIT) begin
                    state_d      = ST_STANDBY;
                    sleep_hold_d = 1'b1;
                end
            end
            ST_FAULT: begin
                if (!en_i) begin
                    state_d = ST_STANDBY;
                end else if (fault_clr_i && ctrl_tx_i) begin
                    state_d = ST_NORMAL;
                end
            end
            default: state_d = ST_STANDBY;
        endcase

        if (!en_i) begin
            sleep_hold_d = 1'b0;
        end

        if (state_d != state_q) begin
            cnt_d      = 16'd0;
            idle_cnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_STANDBY;
            cnt_q        <= 16'd0;
            idle_cnt_q   <= 16'd0;
            wup_cnt_q    <= 16'd0;
            wup_armed_q  <= 1'b1;
            sleep_hold_q <= 1'b0;
            dom_fault_q  <= 1'b0;
            wake_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            wup_cnt_q    <= wup_cnt_d;
            wup_armed_q  <= wup_armed_d;
            sleep_hold_q <= sleep_hold_d;
            dom_fault_q  <= dom_fault_d;
            wake_q       <= wake_d;
        end
    end

    assign xcvr_rs_o   = (state_q == ST_STANDBY);
    assign xcvr_tx_o   = (state_q == ST_NORMAL) ? ctrl_tx_i : 1'b1;
    assign ctrl_rx_o   = (state_q == ST_NORMAL || state_q == ST_FAULT) ? xcvr_rx_i : 1'b1;
    assign ready_o     = (state_q == ST_NORMAL);
    assign dom_fault_o = dom_fault_q;
    assign wake_o      = wake_q;

endmodule

// File: tb/tb_can_xcvr_ctrl.sv
// Bench for can_xcvr_ctrl: directed scenarios plus randomized traffic, all
// checked against a cycle model built from run lengths and elapsed-cycle counts.
module tb_can_xcvr_ctrl;

    localparam int WAKE_CYCLES = 4;
    localparam int DOM_TIMEOUT = 16;
    localparam int IDLE_CYCLES = 8;
    localparam int WUP_FILT    = 3;
    localparam logic [5:0] RESET_OUTS = 6'b111000;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic en_i = 1'b0;
    logic auto_sleep_i = 1'b0;
    logic fault_clr_i = 1'b0;
    logic ctrl_tx_i = 1'b1;
    logic xcvr_rx_i = 1'b1;
    logic xcvr_tx_o, xcvr_rs_o, ctrl_rx_o, ready_o, dom_fault_o, wake_o;

    int vectors = 0;
    int miscompares = 0;

    typedef enum {M_STANDBY, M_WAKE, M_NORMAL, M_FAULT} m_mode_e;
    m_mode_e m_mode;
    int m_wake_elapsed, m_dom_run, m_idle_run, m_low_run;
    bit m_armed, m_hold, m_fault, m_wake;

    can_xcvr_ctrl #(
        .WAKE_CYCLES(WAKE_CYCLES),
        .DOM_TIMEOUT(DOM_TIMEOUT),
        .IDLE_CYCLES(IDLE_CYCLES),
        .WUP_FILT(WUP_FILT)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .en_i(en_i),
        .auto_sleep_i(auto_sleep_i),
        .fault_clr_i(fault_clr_i),
        .ctrl_tx_i(ctrl_tx_i),
        .xcvr_rx_i(xcvr_rx_i),
        .xcvr_tx_o(xcvr_tx_o),
        .xcvr_rs_o(xcvr_rs_o),
        .ctrl_rx_o(ctrl_rx_o),
        .ready_o(ready_o),
        .dom_fault_o(dom_fault_o),
        .wake_o(wake_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] observed();
        return {xcvr_rs_o, xcvr_tx_o, ctrl_rx_o, ready_o, dom_fault_o, wake_o};
    endfunction

    // Expected outputs: which side drives each pin depends only on the mode
    function automatic logic [5:0] model_out();
        logic rs, tx, crx, rdy;
        rs  = (m_mode == M_STANDBY);
        tx  = (m_mode == M_NORMAL) ? ctrl_tx_i : 1'b1;
        crx = (m_mode == M_NORMAL || m_mode == M_FAULT) ? xcvr_rx_i : 1'b1;
        rdy = (m_mode == M_NORMAL);
        return {rs, tx, crx, rdy, m_fault, m_wake};
    endfunction

    task automatic model_reset();
        m_mode = M_STANDBY;
        m_wake_elapsed = 0;
        m_dom_run = 0;
        m_idle_run = 0;
        m_low_run = 0;
        m_armed = 1'b1;
        m_hold = 1'b0;
        m_fault = 1'b0;
        m_wake = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held this cycle
    task automatic model_step();
        m_mode_e nxt;
        bit nfault, nhold, pulse;
        nxt = m_mode;
        nfault = m_fault;
        nhold = m_hold;
        pulse = 1'b0;
        if (m_mode == M_STANDBY && !xcvr_rx_i) begin
            m_low_run++;
            if (m_armed && m_low_run >= WUP_FILT) begin
                pulse = 1'b1;
                m_armed = 1'b0;
                nhold = 1'b0;
            end
        end else begin
            m_low_run = 0;
            m_armed = 1'b1;
        end
        if (fault_clr_i && !(m_mode == M_FAULT && !ctrl_tx_i)) nfault = 1'b0;
        case (m_mode)
            M_STANDBY: if (en_i && !m_hold) nxt = M_WAKE;
            M_WAKE: begin
                if (!en_i) nxt = M_STANDBY;
                else begin
                    m_wake_elapsed++;
                    if (m_wake_elapsed == WAKE_CYCLES) nxt = M_NORMAL;
                end
            end
            M_NORMAL: begin
                m_dom_run = ctrl_tx_i ? 0 : m_dom_run + 1;
                m_idle_run = (ctrl_tx_i && xcvr_rx_i) ? m_idle_run + 1 : 0;
                if (!en_i) nxt = M_STANDBY;
                else if (m_dom_run == DOM_TIMEOUT) begin
                    nxt = M_FAULT;
                    nfault = 1'b1;
                end else if (auto_sleep_i && m_idle_run >= IDLE_CYCLES) begin
                    nxt = M_STANDBY;
                    nhold = 1'b1;
                end
            end
            M_FAULT: begin
                if (!en_i) nxt = M_STANDBY;
                else if (fault_clr_i && ctrl_tx_i) nxt = M_NORMAL;
            end
            default: nxt = M_STANDBY;
        endcase
        if (!en_i) nhold = 1'b0;
        if (nxt != m_mode) begin
            m_wake_elapsed = 0;
            m_dom_run = 0;
            m_idle_run = 0;
        end
        m_mode = nxt;
        m_fault = nfault;
        m_hold = nhold;
        m_wake = pulse;
    endtask

    task automatic apply(input bit en, input bit aslp, input bit clr, input bit tx, input bit rx);
        @(negedge clk_i);
        en_i = en;
        auto_sleep_i = aslp;
        fault_clr_i = clr;
        ctrl_tx_i = tx;
        xcvr_rx_i = rx;
        #1;
    endtask

    task automatic advance();
        @(posedge clk_i);
        model_step();
    endtask

    // Walk from any state into NORMAL with a clean fault flag and no sleep hold
    task automatic bring_up();
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        advance();
        for (int i = 0; i < WAKE_CYCLES + 1; i++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
            advance();
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (observed() !== RESET_OUTS) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got %b expected %b", observed(), RESET_OUTS);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (observed() !== RESET_OUTS) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got %b expected %b", observed(), RESET_OUTS);
        end
        advance();
        for (int n = 0; n < 3; n++) begin
            apply(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("[TB] FAIL reset_idle n=%0d: got %b expected %b", n, observed(), model_out());
            end
            advance();
        end
    endtask

    task automatic test_enable();
        bit tx, rx;
        for (int n = 0; n < 9; n++) begin
            tx = 1'($urandom_range(0, 1));
            rx = (n >= 1 && n <= WAKE_CYCLES) ? 1'b0 : 1'($urandom_range(0, 1));
            apply(1'b1, 1'b0, 1'b0, tx, rx);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("[TB] FAIL enable_model n=%0d: got %b expected %b", n, observed(), model_out());
            end
            vectors++;
            if ({xcvr_rs_o, ready_o} !== {n == 0, n >= WAKE_CYCLES + 1}) begin
                miscompares++;
                $display("[TB] FAIL enable_timing n=%0d: rs/ready got %b%b expected %b%b",
                         n, xcvr_rs_o, ready_o, n == 0, n >= WAKE_CYCLES + 1);
            end
            if (n >= 1 && n <= WAKE_CYCLES) begin
                vectors++;
                if ({ctrl_rx_o, xcvr_tx_o} !== 2'b11) begin
                    miscompares++;
                    $display("[TB] FAIL enable_wake_hold n=%0d: rx/tx got %b%b expected 11", n, ctrl_rx_o, xcvr_tx_o);
                end
            end
            if (n > WAKE_CYCLES) begin
                vectors++;
                if (xcvr_tx_o !== tx) begin
                    miscompares++;
                    $display("[TB] FAIL enable_tx_path n=%0d: got %b expected %b", n, xcvr_tx_o, tx);
                end
            end
            advance();
        end
    endtask

    task automatic test_dom_timeout();
        int low_seen;
        bring_up();
        low_seen = 0;
        for (int n = 0; n < 20; n++) begin
            apply(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            if (xcvr_tx_o === 1'b0) low_seen++;
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("[TB] FAIL dom_model n=%0d: got %b expected %b", n, observed(), model_out());
            end
            advance();
        end
        vectors++;
        if (low_seen != DOM_TIMEOUT) begin
            miscompares++;
            $display("[TB] FAIL dom_low_cycles: got %0d expected %0d", low_seen, DOM_TIMEOUT);
        end
        for (int n = 0; n < 3; n++) begin
            apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            vectors++;
            if ({dom_fault_o, ready_o, xcvr_tx_o} !== 3'b101) begin
                miscompares++;
                $display("[TB] FAIL dom_clr_ignored n=%0d: fault/ready/tx got %b%b%b expected 101",
                         n, dom_fault_o, ready_o, xcvr_tx_o);
            end
            advance();
        end
        apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        vectors++;
        if (observed() !== model_out()) begin
            miscompares++;
            $display("[TB] FAIL dom_clr_cycle: got %b expected %b", observed(), model_out());
        end
        advance();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({dom_fault_o, ready_o} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL dom_recovered: fault/ready got %b%b expected 01", dom_fault_o, ready_o);
        end
        advance();
    endtask

    task automatic test_auto_sleep();
        bring_up();
        for (int n = 0; n < 13; n++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            vectors++;
            if ({xcvr_rs_o, ready_o} !== {n >= IDLE_CYCLES, n < IDLE_CYCLES}) begin
                miscompares++;
                $display("[TB] FAIL sleep_timing n=%0d: rs/ready got %b%b expected %b%b",
                         n, xcvr_rs_o, ready_o, n >= IDLE_CYCLES, n < IDLE_CYCLES);
            end
            advance();
        end
        apply(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        advance();
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (observed() !== model_out()) begin
            miscompares++;
            $display("[TB] FAIL sleep_reenable: got %b expected %b", observed(), model_out());
        end
        advance();
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({xcvr_rs_o, ready_o} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL sleep_rewake: rs/ready got %b%b expected 00", xcvr_rs_o, ready_o);
        end
        advance();
    endtask

    task automatic test_wakeup();
        int pulses;
        bring_up();
        for (int n = 0; n < IDLE_CYCLES + 1; n++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
            advance();
        end
        pulses = 0;
        for (int n = 0; n < 4; n++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, n >= 2);
            if (wake_o === 1'b1) pulses++;
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("[TB] FAIL wup_short_model n=%0d: got %b expected %b", n, observed(), model_out());
            end
            advance();
        end
        vectors++;
        if (pulses != 0 || xcvr_rs_o !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL wup_short: pulses %0d rs %b expected 0 and 1", pulses, xcvr_rs_o);
        end
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            apply(1'b1, 1'b1, 1'b0, 1'b1, n >= 5);
            if (wake_o === 1'b1) pulses++;
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("[TB] FAIL wup_long_model n=%0d: got %b expected %b", n, observed(), model_out());
            end
            if (n == 4) begin
                vectors++;
                if (xcvr_rs_o !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL wup_to_wake: rs got %b expected 0", xcvr_rs_o);
                end
            end
            advance();
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("[TB] FAIL wup_pulse_count: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_timeout_vs_disable();
        bring_up();
        for (int n = 0; n < DOM_TIMEOUT; n++) begin
            apply(n != DOM_TIMEOUT - 1, 1'b0, 1'b0, 1'b0, 1'b1);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("[TB] FAIL tvd_model n=%0d: got %b expected %b", n, observed(), model_out());
            end
            advance();
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if ({xcvr_rs_o, dom_fault_o} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL tvd_result: rs/fault got %b%b expected 10", xcvr_rs_o, dom_fault_o);
        end
        advance();
    endtask

    task automatic test_reset_in_wake();
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        advance();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        advance();
        apply(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        vectors++;
        if (xcvr_rs_o !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_wake_entry: rs got %b expected 0", xcvr_rs_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        vectors++;
        if (observed() !== RESET_OUTS) begin
            miscompares++;
            $display("[TB] FAIL rst_async: got %b expected %b", observed(), RESET_OUTS);
        end
        @(negedge clk_i);
        en_i = 1'b0;
        rst_i = 1'b0;
        model_reset();
        advance();
    endtask

    task automatic test_random();
        bit tx_val, rx_val;
        int tx_left, rx_left;
        tx_val = 1'b1;
        rx_val = 1'b1;
        tx_left = 0;
        rx_left = 0;
        for (int n = 0; n < 700; n++) begin
            if (tx_left == 0) begin
                tx_val = 1'($urandom_range(0, 1));
                tx_left = int'($urandom_range(1, 20));
            end
            if (rx_left == 0) begin
                rx_val = ($urandom_range(0, 2) != 0);
                rx_left = int'($urandom_range(1, 12));
            end
            tx_left--;
            rx_left--;
            apply($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 7) == 0, tx_val, rx_val);
            vectors++;
            if (observed() !== model_out()) begin
                miscompares++;
                $display("[TB] FAIL random n=%0d: got %b expected %b", n, observed(), model_out());
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_enable();
        test_dom_timeout();
        test_auto_sleep();
        test_wakeup();
        test_timeout_vs_disable();
        test_reset_in_wake();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
